// File: rtl/ping_responder_if.sv
//==============================================================================
// Module      : ping_responder_if
// Description : icosoc-style ctrl bus between a CPU (master) and the ping
//               responder register block (slave).
//   ctrl_wr   [3:0]  master->slave  byte write strobes, any bit set = write
//   ctrl_rd          master->slave  read strobe
//   ctrl_addr [15:0] master->slave  register byte address
//   ctrl_wdat [31:0] master->slave  write data
//   ctrl_rdat [31:0] slave->master  read data, valid while ctrl_done is high
//   ctrl_done        slave->master  one-cycle access-complete pulse
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ping_responder_if;
    logic [3:0]  ctrl_wr;
    logic        ctrl_rd;
    logic [15:0] ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;

    modport master (
        output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
        input  ctrl_rdat, ctrl_done
    );

    modport slave (
        input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
        output ctrl_rdat, ctrl_done
    );
endinterface

`default_nettype wire

// File: rtl/ping_responder.sv
//==============================================================================
// Module      : ping_responder
// Description : HC-SR04-style ultrasonic sensor emulator. A trigger pulse on
//               trig_in of at least TRIG_MIN cycles is answered, ECHO_DELAY
//               cycles after its (synchronised) falling edge, by a high pulse
//               on echo_out whose width encodes the programmed distance in cm.
//               Distance 255 emulates "no echo" (long busy period, no pulse).
// Ports       :
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   ctrl      slave modport of ping_responder_if (CPU register access)
//   trig_in   in   trigger from the ping initiator (asynchronous)
//   echo_out  out  echo pulse to the initiator, driven straight from a flop
// Registers   : 0x00 DIST[7:0] R/W, 0x04 CTRL[0] enable R/W,
//               0x08 STATUS R: [0] busy, [15:8] ping_count, [23:16] short_count;
//               any write to 0x08 clears both counters.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ping_responder #(
    parameter int unsigned TRIG_MIN       = 200,    // min trigger width (>= 1)
    parameter int unsigned ECHO_DELAY     = 4000,   // sync fall -> echo rise (>= 2)
    parameter int unsigned CM_CYCLES      = 1161,   // echo cycles per cm
    parameter int unsigned HOLDOFF        = 1000,   // dead time after echo (>= 1)
    parameter int unsigned NO_ECHO_CYCLES = 760000  // busy time for dist 255 (>= 1)
) (
    input  wire              clk,
    input  wire              reset,
    ping_responder_if.slave  ctrl,
    input  wire              trig_in,
    output logic             echo_out
);

    localparam logic [15:0] c_ADDR_DIST   = 16'h0000;
    localparam logic [15:0] c_ADDR_CTRL   = 16'h0004;
    localparam logic [15:0] c_ADDR_STATUS = 16'h0008;

    // Terminal counts for the 24-bit state counter.
    localparam logic [23:0] c_TRIG_MIN_M1 = 24'(TRIG_MIN - 1);
    // The cycle that detects the trigger fall already counts as the first
    // delay cycle, so the echo rises exactly ECHO_DELAY cycles after the
    // synchronised trigger level drops.
    localparam logic [23:0] c_DELAY_LAST  = 24'(ECHO_DELAY - 2);
    localparam logic [23:0] c_NOECHO_LAST = 24'(NO_ECHO_CYCLES - 1);
    localparam logic [23:0] c_HOLD_LAST   = 24'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG_HI = 3'd1,
        S_DELAY   = 3'd2,
        S_ECHO    = 3'd3,
        S_NOECHO  = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic        r_sync1;
    logic        r_sync2;
    logic        r_trig_d;      // previous synchronised level, for edge detect
    logic [7:0]  r_dist;
    logic        r_enable;
    logic [7:0]  r_dist_l;      // distance captured for the ping in flight
    logic [7:0]  r_ping_cnt;
    logic [7:0]  r_short_cnt;
    logic [23:0] r_cnt;
    state_t      r_state;

    //--------------------------------------------------------------------------
    // Bus decode. An access is accepted only while ctrl_done is low, which
    // is what keeps ctrl_done from ever being high two cycles in a row.
    //--------------------------------------------------------------------------
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_dist;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_abort;
    logic        w_rise;
    logic [31:0] w_rd_data;
    logic [31:0] w_echo_len;
    logic        w_unused;

    assign w_wr        = ~ctrl.ctrl_done & (|ctrl.ctrl_wr);
    assign w_rd        = ~ctrl.ctrl_done & ctrl.ctrl_rd;
    assign w_wr_dist   = w_wr & (ctrl.ctrl_addr == c_ADDR_DIST);
    assign w_wr_ctrl   = w_wr & (ctrl.ctrl_addr == c_ADDR_CTRL);
    assign w_wr_status = w_wr & (ctrl.ctrl_addr == c_ADDR_STATUS);
    // Clearing enable kills the ping in the same cycle the write completes.
    assign w_abort     = w_wr_ctrl & ~ctrl.ctrl_wdat[0];
    assign w_rise      = r_sync2 & ~r_trig_d;
    assign w_echo_len  = 32'(r_dist_l) * CM_CYCLES + CM_CYCLES / 2;
    assign w_unused    = &{1'b0, ctrl.ctrl_wdat[31:8]};

    always_comb begin
        w_rd_data = 32'd0;
        case (ctrl.ctrl_addr)
            c_ADDR_DIST:   w_rd_data = {24'd0, r_dist};
            c_ADDR_CTRL:   w_rd_data = {31'd0, r_enable};
            c_ADDR_STATUS: w_rd_data = {8'd0, r_short_cnt, r_ping_cnt, 7'd0,
                                        (r_state != S_IDLE)};
            default:       w_rd_data = 32'd0;
        endcase
    end

    //--------------------------------------------------------------------------
    // Trigger synchroniser plus one delay flop for edge detection
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_trig_d <= 1'b0;
        end else begin
            r_sync1  <= trig_in;
            r_sync2  <= r_sync1;
            r_trig_d <= r_sync2;
        end
    end

    //--------------------------------------------------------------------------
    // Register file and bus response
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl.ctrl_done <= 1'b0;
            ctrl.ctrl_rdat <= 32'd0;
            r_dist         <= 8'd0;
            r_enable       <= 1'b0;
        end else begin
            ctrl.ctrl_done <= w_wr | w_rd;
            ctrl.ctrl_rdat <= w_rd ? w_rd_data : 32'd0;
            if (w_wr_dist) begin
                r_dist <= ctrl.ctrl_wdat[7:0];
            end
            if (w_wr_ctrl) begin
                r_enable <= ctrl.ctrl_wdat[0];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Ping state machine and statistics counters
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 24'd0;
            echo_out    <= 1'b0;
            r_dist_l    <= 8'd0;
            r_ping_cnt  <= 8'd0;
            r_short_cnt <= 8'd0;
        end else begin
            // A STATUS write wins over any increment in the same cycle.
            if (w_wr_status) begin
                r_ping_cnt  <= 8'd0;
                r_short_cnt <= 8'd0;
            end

            if (w_abort) begin
                r_state  <= S_IDLE;
                r_cnt    <= 24'd0;
                echo_out <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_enable && w_rise) begin
                            r_state <= S_TRIG_HI;
                            r_cnt   <= 24'd0;
                        end
                    end

                    // The rising-edge cycle is part of the measured width,
                    // hence the comparison against TRIG_MIN-1.
                    S_TRIG_HI: begin
                        if (r_sync2) begin
                            if (r_cnt != 24'hFF_FFFF) begin
                                r_cnt <= r_cnt + 24'd1;
                            end
                        end else begin
                            r_cnt <= 24'd0;
                            if (r_cnt >= c_TRIG_MIN_M1) begin
                                r_dist_l <= r_dist;
                                if (!w_wr_status) begin
                                    r_ping_cnt <= r_ping_cnt + 8'd1;
                                end
                                r_state <= S_DELAY;
                            end else begin
                                if (!w_wr_status && (r_short_cnt != 8'hFF)) begin
                                    r_short_cnt <= r_short_cnt + 8'd1;
                                end
                                r_state <= S_IDLE;
                            end
                        end
                    end

                    S_DELAY: begin
                        if (r_cnt >= c_DELAY_LAST) begin
                            r_cnt <= 24'd0;
                            if (r_dist_l == 8'hFF) begin
                                r_state <= S_NOECHO;
                            end else begin
                                r_state  <= S_ECHO;
                                echo_out <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 24'd1;
                        end
                    end

                    S_ECHO: begin
                        if ({8'd0, r_cnt} >= w_echo_len - 32'd1) begin
                            r_cnt    <= 24'd0;
                            echo_out <= 1'b0;
                            r_state  <= S_HOLD;
                        end else begin
                            r_cnt <= r_cnt + 24'd1;
                        end
                    end

                    S_NOECHO: begin
                        if (r_cnt >= c_NOECHO_LAST) begin
                            r_cnt   <= 24'd0;
                            r_state <= S_HOLD;
                        end else begin
                            r_cnt <= r_cnt + 24'd1;
                        end
                    end

                    S_HOLD: begin
                        if (r_cnt >= c_HOLD_LAST) begin
                            r_cnt   <= 24'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 24'd1;
                        end
                    end

                    default: begin
                        r_cnt    <= 24'd0;
                        echo_out <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ping_responder.sv
//==============================================================================
// Module      : tb_ping_responder
// Description : Self-checking bench for ping_responder. Timing parameters are
//               scaled down so every scenario, including counter wrap and
//               saturation, fits in a short run. Expected values come from a
//               small reference model of the register/ping rules.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ping_responder;

    localparam int TRIG_MIN       = 8;
    localparam int ECHO_DELAY     = 20;
    localparam int CM_CYCLES      = 10;
    localparam int HOLDOFF        = 12;
    localparam int NO_ECHO_CYCLES = 100;

    localparam logic [15:0] A_DIST   = 16'h0000;
    localparam logic [15:0] A_CTRL   = 16'h0004;
    localparam logic [15:0] A_STATUS = 16'h0008;
    localparam logic [15:0] A_BAD    = 16'h000C;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic trig_in = 1'b0;
    logic echo_out;

    ping_responder_if bus();

    ping_responder #(
        .TRIG_MIN       (TRIG_MIN),
        .ECHO_DELAY     (ECHO_DELAY),
        .CM_CYCLES      (CM_CYCLES),
        .HOLDOFF        (HOLDOFF),
        .NO_ECHO_CYCLES (NO_ECHO_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ctrl     (bus),
        .trig_in  (trig_in),
        .echo_out (echo_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_dist  = 0;
    int m_en    = 0;
    int m_ping  = 0;
    int m_short = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int exp_width(input int d);
        return d * CM_CYCLES + CM_CYCLES / 2;
    endfunction

    function automatic logic [31:0] exp_status(input int busy);
        return {8'd0, 8'(m_short), 8'(m_ping), 7'd0, 1'(busy)};
    endfunction

    // An accepted trigger (issued while idle and enabled) updates the counters.
    task automatic model_trigger(input int h);
        if (h >= TRIG_MIN) m_ping = (m_ping + 1) % 256;
        else if (m_short < 255) m_short++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        bus.ctrl_addr = a;
        bus.ctrl_wdat = d;
        bus.ctrl_wr   = 4'hF;
        tick();
        check_eq("wr_done", 32'(bus.ctrl_done), 32'd1);
        check_eq("wr_rdat_zero", bus.ctrl_rdat, 32'd0);
        bus.ctrl_wr = 4'h0;
        tick();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        bus.ctrl_addr = a;
        bus.ctrl_rd   = 1'b1;
        tick();
        check_eq("rd_done", 32'(bus.ctrl_done), 32'd1);
        d = bus.ctrl_rdat;
        bus.ctrl_rd = 1'b0;
        tick();
    endtask

    task automatic check_status(input string tag, input int busy);
        logic [31:0] v;
        bus_read(A_STATUS, v);
        check_eq(tag, v, exp_status(busy));
    endtask

    task automatic pulse(input int h);
        trig_in = 1'b1;
        repeat (h) tick();
        trig_in = 1'b0;
    endtask

    // Cycles from the trigger fall to the first high echo sample; -1 on timeout.
    task automatic wait_rise(output int k);
        k = 0;
        while (!echo_out && k < ECHO_DELAY + 40) begin
            tick();
            k++;
        end
        if (!echo_out) k = -1;
    endtask

    task automatic wait_fall(input int c1, output int w);
        int n = 0;
        while (echo_out && n < 4000) begin
            tick();
            n++;
        end
        w = echo_out ? -1 : cyc - c1;
    endtask

    task automatic watch(input int n, inout int seen);
        repeat (n) begin
            tick();
            if (echo_out) seen = 1;
        end
    endtask

    // Full valid ping with current DIST: checks delay and width, waits out holdoff.
    task automatic run_ping(input string tag, input int h);
        int k, w, c1;
        pulse(h);
        model_trigger(h);
        wait_rise(k);
        check_eq({tag, "_delay"}, 32'(k), 32'(ECHO_DELAY + 2));
        c1 = cyc;
        wait_fall(c1, w);
        check_eq({tag, "_width"}, 32'(w), 32'(exp_width(m_dist)));
        repeat (HOLDOFF + 2) tick();
    endtask

    task automatic set_dist(input int d);
        bus_write(A_DIST, 32'(d));
        m_dist = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int k, w, c1, seen, h, d;

        bus.ctrl_wr   = 4'h0;
        bus.ctrl_rd   = 1'b0;
        bus.ctrl_addr = 16'h0;
        bus.ctrl_wdat = 32'h0;

        // ---------------- Reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_echo", 32'(echo_out), 32'd0);
        check_eq("rst_done", 32'(bus.ctrl_done), 32'd0);
        check_eq("rst_rdat", bus.ctrl_rdat, 32'd0);
        reset = 1'b0;
        tick();
        bus_read(A_DIST, v);  check_eq("rst_dist", v, 32'd0);
        bus_read(A_CTRL, v);  check_eq("rst_ctrl", v, 32'd0);
        check_status("rst_status", 0);

        // ---------------- Basic ping, DIST=10, minimum trigger ----------------
        set_dist(10);
        bus_write(A_CTRL, 32'h1);
        m_en = 1;
        bus_read(A_DIST, v);  check_eq("rb_dist", v, 32'd10);
        bus_read(A_CTRL, v);  check_eq("rb_ctrl", v, 32'd1);
        pulse(TRIG_MIN);
        model_trigger(TRIG_MIN);
        wait_rise(k);
        check_eq("p10_delay", 32'(k), 32'(ECHO_DELAY + 2));
        c1 = cyc;
        check_status("p10_busy", 1);
        wait_fall(c1, w);
        check_eq("p10_width", 32'(w), 32'(exp_width(10)));
        repeat (HOLDOFF + 2) tick();
        check_status("p10_idle", 0);

        // ---------------- Short trigger then a normal one ----------------
        pulse(TRIG_MIN - 1);
        model_trigger(TRIG_MIN - 1);
        seen = 0;
        watch(ECHO_DELAY + 10, seen);
        check_eq("short_no_echo", 32'(seen), 32'd0);
        check_status("short_status", 0);
        run_ping("after_short", TRIG_MIN + 5);

        // ---------------- No-echo distance with an ignored trigger ----------------
        set_dist(255);
        pulse(TRIG_MIN);
        model_trigger(TRIG_MIN);
        seen = 0;
        watch(30, seen);
        check_status("noecho_busy_early", 1);
        trig_in = 1'b1;
        watch(TRIG_MIN, seen);
        trig_in = 1'b0;
        watch(ECHO_DELAY + NO_ECHO_CYCLES + HOLDOFF - 45, seen);
        check_status("noecho_busy_late", 1);
        check_eq("noecho_no_echo", 32'(seen), 32'd0);
        repeat (10) tick();
        check_status("noecho_idle", 0);

        // ---------------- Extreme distances, trigger during holdoff ----------------
        set_dist(0);
        run_ping("d0", TRIG_MIN);
        // Trigger raised during holdoff and still high when idle returns.
        set_dist(0);
        pulse(TRIG_MIN);
        model_trigger(TRIG_MIN);
        wait_rise(k);
        c1 = cyc;
        wait_fall(c1, w);
        check_eq("hold_w", 32'(w), 32'(exp_width(0)));
        trig_in = 1'b1;
        seen = 0;
        watch(HOLDOFF + 10, seen);
        trig_in = 1'b0;
        watch(ECHO_DELAY + 10, seen);
        check_eq("hold_trig_ignored", 32'(seen), 32'd0);
        check_status("hold_status", 0);

        // DIST=254 with a DIST write mid-echo; next ping uses new value.
        set_dist(254);
        pulse(TRIG_MIN);
        model_trigger(TRIG_MIN);
        wait_rise(k);
        check_eq("d254_delay", 32'(k), 32'(ECHO_DELAY + 2));
        c1 = cyc;
        set_dist(5);
        wait_fall(c1, w);
        check_eq("d254_width", 32'(w), 32'(exp_width(254)));
        repeat (HOLDOFF + 2) tick();
        run_ping("d5_next", TRIG_MIN + 1);

        // ---------------- Randomised pings ----------------
        for (int i = 0; i < 10; i++) begin
            d = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 254));
            set_dist(d);
            if ($urandom % 3 == 0) begin
                h = int'($urandom_range(1, TRIG_MIN - 1));
                pulse(h);
                model_trigger(h);
                seen = 0;
                watch(ECHO_DELAY + 8, seen);
                check_eq("rnd_short_no_echo", 32'(seen), 32'd0);
            end else begin
                h = int'($urandom_range(TRIG_MIN, TRIG_MIN + 12));
                run_ping("rnd", h);
            end
            check_status("rnd_status", 0);
        end

        // ---------------- Reset mid-echo ----------------
        set_dist(200);
        pulse(TRIG_MIN);
        model_trigger(TRIG_MIN);
        wait_rise(k);
        check_eq("rst_mid_rise", 32'(k), 32'(ECHO_DELAY + 2));
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_echo_low", 32'(echo_out), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_dist = 0; m_en = 0; m_ping = 0; m_short = 0;
        tick();
        check_eq("rst_mid_echo_stays_low", 32'(echo_out), 32'd0);
        bus_read(A_DIST, v);  check_eq("rst_mid_dist", v, 32'd0);
        bus_read(A_CTRL, v);  check_eq("rst_mid_ctrl", v, 32'd0);
        check_status("rst_mid_status", 0);

        // ---------------- Enable cleared mid-delay ----------------
        bus_write(A_CTRL, 32'h1);
        m_en = 1;
        set_dist(30);
        pulse(TRIG_MIN);
        model_trigger(TRIG_MIN);
        repeat (5) tick();
        bus_write(A_CTRL, 32'h0);
        m_en = 0;
        check_status("abort_idle", 0);
        seen = 0;
        watch(ECHO_DELAY + exp_width(30) + 10, seen);
        check_eq("abort_no_echo", 32'(seen), 32'd0);
        // Disabled: triggers are not seen at all.
        pulse(TRIG_MIN);
        repeat (6) tick();
        check_status("disabled_ignored", 0);
        bus_write(A_CTRL, 32'h1);
        m_en = 1;

        // ---------------- Bus handshake corners ----------------
        bus.ctrl_addr = A_STATUS;
        bus.ctrl_rd   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("b2b_done", 32'(bus.ctrl_done), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("b2b_rdat", bus.ctrl_rdat, (i % 2 == 0) ? exp_status(0) : 32'd0);
        end
        bus.ctrl_rd = 1'b0;
        tick();
        bus_read(A_BAD, v);  check_eq("bad_addr_read", v, 32'd0);
        bus_write(A_BAD, 32'hFFFF_FFFF);
        bus_read(A_DIST, v); check_eq("bad_addr_write", v, 32'(m_dist));
        bus_write(A_STATUS, 32'h0);
        m_ping = 0; m_short = 0;
        check_status("status_clear", 0);

        // ---------------- Counter saturation and wrap ----------------
        for (int i = 0; i < 260; i++) begin
            h = int'($urandom_range(1, TRIG_MIN - 1));
            pulse(h);
            model_trigger(h);
            repeat (5) tick();
        end
        check_status("short_saturate", 0);
        set_dist(0);
        for (int i = 0; i < 256; i++) begin
            pulse(TRIG_MIN);
            model_trigger(TRIG_MIN);
            repeat (ECHO_DELAY + 2 + exp_width(0) + HOLDOFF + 6) tick();
        end
        check_status("ping_wrap", 0);
        run_ping("post_wrap", TRIG_MIN);
        check_status("post_wrap_status", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
